mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 select datapath (`i[3:0]`, `s[1:0]`, `y`) between four requesters.
- Produces a registered one-hot grant plus the matching 2-bit select, which drives the mux select input directly.
- Holds the grant for a multi-cycle ownership window.
- Optionally preempts a requester that holds ownership longer than a fixed limit.

Parameters:
- HOLD_MAX, 8, maximum consecutive grant cycles before forced rotation. Range 2..255. Used only when ARB_TIMEOUT_EN is defined.
- CNT_W, $clog2(HOLD_MAX), width of the hold counter. Derived; not to be overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit n = requester n wants the datapath.
- grant  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  binary index of current owner; drives the mux select.
- valid  output  1  high when grant is non-zero.
- owner_cnt  output  CNT_W  cycles the current owner has held the grant, starting at 0.

Behaviour:
- Reset (async assert, sync deassert by system): grant=4'b0000, sel=2'b00, valid=0, owner_cnt=0, state=IDLE, last_ptr=3. With last_ptr=3, requester 0 has top priority first.
- All outputs are registered. No combinational path from req to any output.
- States: IDLE, OWN.
- Winner search: scan indices last_ptr+1, +2, +3, +4 (mod 4). Pick the first with req set.
- IDLE:
  - If req != 0: load grant=onehot(winner), sel=winner, last_ptr=winner, owner_cnt=0, go to OWN.
  - Latency is 1 cycle: req sampled at edge k, grant visible after edge k.
  - If req == 0: stay IDLE. grant=0, sel holds its previous value so the mux output stays stable.
- OWN, owner = sel:
  - req[owner]=1 and no preemption: keep grant/sel. owner_cnt increments, saturating at 2^CNT_W-1.
  - req[owner]=0 (release), another req set: at the next edge grant the next winner, searching from last_ptr=owner. No idle bubble. owner_cnt=0.
  - req[owner]=0, no other req: go to IDLE at the next edge. grant=0, valid=0.
  - Simultaneous release and new requests: same as the release case. The released owner is lowest priority in that search.
- Fairness: after any handover the previous owner is searched last. A continuously requesting set of N requesters is served in strict cyclic order.
- Invariants:
  - grant is always zero or one-hot.
  - sel == index(grant) whenever valid=1.
  - grant never changes except at a clock edge.
- Reset mid-ownership: grant drops to 0 immediately (asynchronously). last_ptr returns to 3 and the arbitration history is lost.
- X/unused: req bits may change at any time. Only values sampled at the rising edge matter.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In OWN, when owner_cnt == HOLD_MAX-1, req[owner]=1 and any other req is set: the next edge hands the grant to the next winner (searched from owner). owner_cnt=0.
  - If no other req is set at that point: the owner keeps the grant and owner_cnt restarts at 0.
  - A preempted owner that is still requesting re-enters the rotation normally.
- Not defined:
  - No preemption. The owner keeps the grant until it drops req.
  - owner_cnt still counts and saturates, for observation only.
  - HOLD_MAX only sizes the counter.

Test Plan:
- Reset/first grant: assert rst, then release. Drive req=4'b1111 at edge 0 -> after edge 1: grant=0001, sel=0, valid=1. During rst: grant=0000.
- Rotation: req=1111 held. Each owner drops its req for one cycle after 2 cycles of ownership -> grant sequence 0001, 0010, 0100, 1000, 0001. No cycle with valid=0.
- Idle/hold: single req=0100 for 3 cycles, then 0000 -> grant=0100 for 3 cycles, then 0000, valid=0, sel stays 2. Next req=0001 -> grant=0001 one cycle later.
- Release + new requests: owner 1 drops req in the same cycle req[0] and req[3] assert -> next grant=1000 (search starts at 2), not 0001.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req=0011 held constant -> grant 0001 for exactly 4 cycles, then 0010 for 4, then 0001. With only req=0001: grant never drops and owner_cnt wraps 3 to 0. Without the macro: grant=0001 indefinitely and owner_cnt saturates at 3.
- Async reset mid-ownership: assert rst between clock edges while grant=0100 -> grant=0000 and valid=0 before the next edge. After release with req=0100: grant=0100 one edge later.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 select datapath.
// Produces a registered one-hot grant, the matching binary select for the
// mux, a valid flag and a count of how long the current owner has held it.
// Optional macro ARB_TIMEOUT_EN: preempt an owner after HOLD_MAX cycles when
// another requester is waiting. Undefined (default): owner keeps the grant
// until it drops its request, and owner_cnt is for observation only.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = $clog2(HOLD_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [CNT_W-1:0] owner_cnt
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e           state_q;
  logic [3:0]       grant_q;
  logic [1:0]       sel_q;
  logic             valid_q;
  logic [CNT_W-1:0] owner_cnt_q;
  logic [1:0]       last_ptr_q;

  logic       win_any;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       own_req;
  logic       others_req;
  logic       take_win;
  logic       go_idle;
  logic       cnt_clr;
  logic       cnt_inc;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);
`endif

  // Scan last_ptr+1 .. last_ptr+4 (mod 4); the last owner is considered last.
  always_comb begin
    win_any = 1'b0;
    win_idx = last_ptr_q;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_ptr_q + 2'(k);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign own_req    = req[sel_q];
  assign others_req = |(req & ~grant_q);

  // Decode which action the FSM takes at the next edge.
  always_comb begin
    take_win = 1'b0;
    go_idle  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_any) take_win = 1'b1;
        else         go_idle  = 1'b1;
      end
      StOwn: begin
        if (!own_req) begin
          // Release: hand over without an idle bubble if anyone is waiting.
          if (win_any) take_win = 1'b1;
          else         go_idle  = 1'b1;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (owner_cnt_q == HoldLast) begin
            if (others_req) take_win = 1'b1;
            else            cnt_clr  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
`else
          cnt_inc = 1'b1;
`endif
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // FSM and registered outputs; sel holds through idle to keep the mux stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 4'b0000;
      sel_q       <= 2'd0;
      valid_q     <= 1'b0;
      owner_cnt_q <= '0;
      last_ptr_q  <= 2'd3;
    end else begin
      if (take_win) begin
        state_q     <= StOwn;
        grant_q     <= 4'b0001 << win_idx;
        sel_q       <= win_idx;
        valid_q     <= 1'b1;
        owner_cnt_q <= '0;
        last_ptr_q  <= win_idx;
      end else if (go_idle) begin
        state_q     <= StIdle;
        grant_q     <= 4'b0000;
        valid_q     <= 1'b0;
        owner_cnt_q <= '0;
      end else if (cnt_clr) begin
        owner_cnt_q <= '0;
      end else if (cnt_inc) begin
        if (owner_cnt_q != {CNT_W{1'b1}}) owner_cnt_q <= owner_cnt_q + 1'b1;
      end
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign valid     = valid_q;
  assign owner_cnt = owner_cnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (HOLD_MAX=4, so owner_cnt is 2 bits).
// Expectations for the timeout section follow ARB_TIMEOUT_EN if defined.
module tb_mux_rr_arbiter;

  localparam int unsigned HoldMax = 4;
  localparam int unsigned CntW    = 2;

  typedef struct {
    logic [3:0]      req;
    logic [3:0]      grant;
    logic [1:0]      sel;
    logic            valid;
    logic [CntW-1:0] cnt;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0]      grant;
  logic [1:0]      sel;
  logic            valid;
  logic [CntW-1:0] owner_cnt;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  vec_t sb[$];

  mux_rr_arbiter #(
    .HOLD_MAX(HoldMax)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .valid    (valid),
    .owner_cnt(owner_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, ".grant"}, {4'b0, grant}, {4'b0, e.grant});
    check({tag, ".valid"}, {7'b0, valid}, {7'b0, e.valid});
    check({tag, ".cnt"}, {6'b0, owner_cnt}, {6'b0, e.cnt});
    if (e.valid) check({tag, ".sel"}, {6'b0, sel}, {6'b0, e.sel});
  endtask

  // Drive req away from the active edge, queue the expectation, then compare
  // just after the edge that samples it.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    req = v.req;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                     input logic v, input logic [CntW-1:0] c);
    vec_t e;
    e.req = r; e.grant = g; e.sel = s; e.valid = v; e.cnt = c;
    vecs.push_back(e);
  endtask

  initial begin
    vec_t e;
    rst = 1'b1;
    req = 4'b0000;

    // First grant and rotation with one-cycle drops after two cycles of ownership.
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 2'd0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 2'd1);
    add(4'b1110, 4'b0010, 2'd1, 1'b1, 2'd0);
    add(4'b1111, 4'b0010, 2'd1, 1'b1, 2'd1);
    add(4'b1101, 4'b0100, 2'd2, 1'b1, 2'd0);
    add(4'b1111, 4'b0100, 2'd2, 1'b1, 2'd1);
    add(4'b1011, 4'b1000, 2'd3, 1'b1, 2'd0);
    add(4'b1111, 4'b1000, 2'd3, 1'b1, 2'd1);
    add(4'b0111, 4'b0001, 2'd0, 1'b1, 2'd0);
    // Single requester 2 for three cycles, then idle with sel held at 2.
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 2'd0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 2'd1);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 2'd2);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 2'd0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 2'd0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd0);
    // Owner 1 releases while 0 and 3 assert: search from 2 picks 3.
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 2'd0);
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 2'd1);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 2'd0);
    // req=0011 held: owner 0 for four cycles.
    add(4'b0011, 4'b0001, 2'd0, 1'b1, 2'd0);
    add(4'b0011, 4'b0001, 2'd0, 1'b1, 2'd1);
    add(4'b0011, 4'b0001, 2'd0, 1'b1, 2'd2);
    add(4'b0011, 4'b0001, 2'd0, 1'b1, 2'd3);
`ifdef ARB_TIMEOUT_EN
    add(4'b0011, 4'b0010, 2'd1, 1'b1, 2'd0);
    add(4'b0011, 4'b0010, 2'd1, 1'b1, 2'd1);
    add(4'b0011, 4'b0010, 2'd1, 1'b1, 2'd2);
    add(4'b0011, 4'b0010, 2'd1, 1'b1, 2'd3);
    add(4'b0011, 4'b0001, 2'd0, 1'b1, 2'd0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd1);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd2);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd3);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd1);
`else
    for (int i = 0; i < 5; i++) add(4'b0011, 4'b0001, 2'd0, 1'b1, 2'd3);
    for (int i = 0; i < 5; i++) add(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd3);
`endif
    // Owner 0 releases, requester 2 takes over (set-up for async reset).
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 2'd0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    e.req = 4'b0; e.grant = 4'b0; e.sel = 2'd0; e.valid = 1'b0; e.cnt = '0;
    check_all("reset", e);
    check("reset.sel", {6'b0, sel}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec[%0d]", i), vecs[i]);

    // Asynchronous reset between edges while requester 2 owns the datapath.
    #2;
    rst = 1'b1;
    #1;
    e.req = 4'b0; e.grant = 4'b0; e.sel = 2'd0; e.valid = 1'b0; e.cnt = '0;
    check_all("async_rst", e);
    check("async_rst.sel", {6'b0, sel}, 8'h00);
    req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // History lost: last_ptr back to 3, so 1010 grants requester 1, not 3.
    e.req = 4'b1010; e.grant = 4'b0010; e.sel = 2'd1; e.valid = 1'b1; e.cnt = '0;
    step("post_rst0", e);
    e.req = 4'b0100; e.grant = 4'b0100; e.sel = 2'd2; e.valid = 1'b1; e.cnt = '0;
    step("post_rst1", e);
    e.req = 4'b0000; e.grant = 4'b0000; e.sel = 2'd2; e.valid = 1'b0; e.cnt = '0;
    step("post_rst2", e);
    check("post_rst2.sel_hold", {6'b0, sel}, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
